// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the peripheral clock-gating controller.
// Optional wake synchronizer is selected by CLK_GATE_CTRL_WAKE_SYNC_EN.
package clk_gate_ctrl_pkg;

    localparam int unsigned CYCLES_MIN = 1;
    localparam int unsigned CYCLES_MAX = 255;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_IDLE_CHK = 2'd1,
        ST_GATED    = 2'd2,
        ST_WAKE     = 2'd3
    } gate_state_e;

    // Force a cycle-count parameter into its legal range.
    function automatic int unsigned clamp_cycles(input int unsigned v);
        if (v < CYCLES_MIN) begin
            return CYCLES_MIN;
        end
        if (v > CYCLES_MAX) begin
            return CYCLES_MAX;
        end
        return v;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_sync_2ff.sv
// One-bit two-flop synchronizer with asynchronous active-low reset (resets to 0).
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Peripheral clock-gating controller: idle-qualified gate entry, wake with settle and done pulse.
// Define CLK_GATE_CTRL_WAKE_SYNC_EN to pass WAKEUP through a two-flop synchronizer.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic GATE_REQ,
    input  logic PERIPH_IDLE,
    input  logic WAKEUP,
    output logic CLKEN,
    output logic GATED,
    output logic WAKE_DONE
);

    localparam int unsigned IDLE_EFF = clamp_cycles(IDLE_CYCLES);
    localparam int unsigned WAKE_EFF = clamp_cycles(WAKE_CYCLES);
    localparam int unsigned CNT_W    = $clog2(max_u(IDLE_EFF, WAKE_EFF) + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] IDLE_CNT = CNT_W'(IDLE_EFF);
    localparam logic [CNT_W-1:0] WAKE_CNT = CNT_W'(WAKE_EFF);

    gate_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clken;
    logic             r_gated;
    logic             r_wake_done;

    logic             w_wakeup;
    logic [CNT_W-1:0] w_cnt_inc;

`ifdef CLK_GATE_CTRL_WAKE_SYNC_EN
    sync_2ff u_wake_sync (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_d     (WAKEUP),
        .o_q     (w_wakeup)
    );
`else
    assign w_wakeup = WAKEUP;
`endif

    // Saturating increment; the counter never wraps.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_clken     <= 1'b1;
            r_gated     <= 1'b0;
            r_wake_done <= 1'b0;
        end else begin
            r_wake_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_clken <= 1'b1;
                    r_gated <= 1'b0;
                    if (GATE_REQ && !w_wakeup) begin
                        r_state <= ST_IDLE_CHK;
                        r_cnt   <= '0;
                    end
                end
                ST_IDLE_CHK: begin
                    if (w_wakeup || !GATE_REQ) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else if (!PERIPH_IDLE) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // This sample completes the required run of idle cycles.
                        if (w_cnt_inc >= IDLE_CNT) begin
                            r_state <= ST_GATED;
                            r_clken <= 1'b0;
                            r_gated <= 1'b1;
                        end
                    end
                end
                ST_GATED: begin
                    if (w_wakeup || !GATE_REQ) begin
                        r_state <= ST_WAKE;
                        r_cnt   <= '0;
                        r_clken <= 1'b1;
                        r_gated <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= WAKE_CNT) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_wake_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                    r_clken <= 1'b1;
                    r_gated <= 1'b0;
                end
            endcase
        end
    end

    assign CLKEN     = r_clken;
    assign GATED     = r_gated;
    assign WAKE_DONE = r_wake_done;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clk_gate_ctrl;

`ifdef CLK_GATE_CTRL_WAKE_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    localparam logic [2:0] E_RUN   = 3'b100;
    localparam logic [2:0] E_GATED = 3'b010;
    localparam logic [2:0] E_DONE  = 3'b101;

    typedef struct {
        logic [2:0] exp;
        string      name;
    } exp_t;

    logic HCLK;
    logic HRESETn;
    logic GATE_REQ;
    logic PERIPH_IDLE;
    logic WAKEUP;
    logic CLKEN;
    logic GATED;
    logic WAKE_DONE;

    exp_t exp_q[$];
    int   total;
    int   bad;

    clk_gate_ctrl #(
        .IDLE_CYCLES (4),
        .WAKE_CYCLES (2)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .GATE_REQ    (GATE_REQ),
        .PERIPH_IDLE (PERIPH_IDLE),
        .WAKEUP      (WAKEUP),
        .CLKEN       (CLKEN),
        .GATED       (GATED),
        .WAKE_DONE   (WAKE_DONE)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: clken/gated/done got=%b want=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic gr, input logic pi, input logic wk,
                        input logic [2:0] e, input string nm);
        exp_t item;
        @(negedge HCLK);
        GATE_REQ    = gr;
        PERIPH_IDLE = pi;
        WAKEUP      = wk;
        item.exp    = e;
        item.name   = nm;
        exp_q.push_back(item);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge HCLK);
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic release_gate(input string nm);
        step(1'b0, 1'b1, 1'b0, E_RUN,  {nm, "_ungate"});
        step(1'b0, 1'b1, 1'b0, E_RUN,  {nm, "_settle"});
        step(1'b0, 1'b1, 1'b0, E_DONE, {nm, "_done"});
        step(1'b0, 1'b1, 1'b0, E_RUN,  {nm, "_run"});
        step(1'b0, 1'b1, 1'b0, E_RUN,  {nm, "_run"});
    endtask

    // Monitor: compare DUT outputs against the head of the scoreboard after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, {CLKEN, GATED, WAKE_DONE}, e.exp);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total       = 0;
        bad         = 0;
        GATE_REQ    = 1'b0;
        PERIPH_IDLE = 1'b0;
        WAKEUP      = 1'b0;
        HRESETn     = 1'b1;
        #1 HRESETn  = 1'b0;
        #2 chk("reset_async", {CLKEN, GATED, WAKE_DONE}, E_RUN);
        repeat (2) @(posedge HCLK);
        #1 chk("reset_held", {CLKEN, GATED, WAKE_DONE}, E_RUN);
        @(negedge HCLK);
        HRESETn = 1'b1;

        repeat (3) step(1'b0, 1'b0, 1'b0, E_RUN, "run_idle");
        repeat (2) step(1'b0, 1'b1, 1'b0, E_RUN, "run_no_req");

        // Gate entry: request at edge 0, idle at edges 1..4.
        step(1'b1, 1'b1, 1'b0, E_RUN, "gate_edge0");
        repeat (3) step(1'b1, 1'b1, 1'b0, E_RUN, "gate_count");
        step(1'b1, 1'b1, 1'b0, E_GATED, "gate_edge4");
        repeat (3) step(1'b1, 1'b1, 1'b0, E_GATED, "gated_hold");

        // Wake pulse; ungate appears SL edges later when synchronized.
        for (int i = 0; i <= SL; i++) begin
            step(1'b1, 1'b1, (i == 0), (i == SL) ? E_RUN : E_GATED, "wake_ungate");
        end
        step(1'b1, 1'b1, 1'b0, E_RUN,  "wake_settle");
        step(1'b1, 1'b1, 1'b0, E_DONE, "wake_done");
        step(1'b1, 1'b1, 1'b0, E_RUN,  "regate_enter");
        repeat (3) step(1'b1, 1'b1, 1'b0, E_RUN, "regate_count");
        step(1'b1, 1'b1, 1'b0, E_GATED, "regate_gated");
        release_gate("rel1");

        // Busy sample at edge 3 restarts the idle count.
        step(1'b1, 1'b1, 1'b0, E_RUN, "restart_edge0");
        repeat (2) step(1'b1, 1'b1, 1'b0, E_RUN, "restart_count");
        step(1'b1, 1'b0, 1'b0, E_RUN, "restart_busy");
        repeat (3) step(1'b1, 1'b1, 1'b0, E_RUN, "restart_recount");
        step(1'b1, 1'b1, 1'b0, E_GATED, "restart_gated");
        release_gate("rel2");

        // Request dropped mid-check aborts to RUN; the next attempt starts over.
        repeat (3) step(1'b1, 1'b1, 1'b0, E_RUN, "abort_count");
        step(1'b0, 1'b1, 1'b0, E_RUN, "abort_drop");
        step(1'b1, 1'b1, 1'b0, E_RUN, "abort_reenter");
        repeat (3) step(1'b1, 1'b1, 1'b0, E_RUN, "abort_recount");
        step(1'b1, 1'b1, 1'b0, E_GATED, "abort_gated");
        release_gate("rel3");

        // WAKEUP and GATE_REQ together: wake wins, clock never gates.
        repeat (8) step(1'b1, 1'b1, 1'b1, E_RUN, "wake_priority");
        repeat (4) step(1'b0, 1'b0, 1'b0, E_RUN, "priority_clear");

        // Reset while gated ungates without a clock edge.
        step(1'b1, 1'b1, 1'b0, E_RUN, "rst_gate_edge0");
        repeat (3) step(1'b1, 1'b1, 1'b0, E_RUN, "rst_gate_count");
        step(1'b1, 1'b1, 1'b0, E_GATED, "rst_gate_gated");
        drain();
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1 chk("reset_in_gated", {CLKEN, GATED, WAKE_DONE}, E_RUN);
        @(posedge HCLK);
        #1 chk("reset_in_gated_held", {CLKEN, GATED, WAKE_DONE}, E_RUN);
        @(negedge HCLK);
        GATE_REQ = 1'b0;
        HRESETn  = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0, E_RUN, "post_reset");

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
